// File: rtl/mem_wb_pipe_reg_if.sv
// Handshake/data bundle between the memory stage, the MEM/WB register and the
// register-file write port. The master drives results in and consumes writebacks.
interface mem_wb_pipe_reg_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int CTRL_W  = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [XLEN-1:0]    mem_read_data;
    logic [XLEN-1:0]    alu_out;
    logic [RADDR_W-1:0] rd;
    logic [2:0]         funct3;
    logic [CTRL_W-1:0]  ctrl;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    wb_data;
    logic [RADDR_W-1:0] wb_rd;
    logic               wb_we;

    modport master (
        output in_valid, mem_read_data, alu_out, rd, funct3, ctrl, out_ready,
        input  in_ready, out_valid, wb_data, wb_rd, wb_we
    );

    modport slave (
        input  in_valid, mem_read_data, alu_out, rd, funct3, ctrl, out_ready,
        output in_ready, out_valid, wb_data, wb_rd, wb_we
    );
endinterface

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register with a 2-entry skid buffer, flush, writeback mux and x0 write gating.
// Optional load alignment/extension is compiled in with `define MEM_WB_LOAD_ALIGN_EN.
module mem_wb_pipe_reg #(
    parameter int XLEN       = 32,
    parameter int RADDR_W    = 5,
    parameter int CTRL_W     = 8,
    parameter int WB_SEL_BIT = 2,
    parameter int RWE_BIT    = 0
) (
    input logic               clk,
    input logic               rst,
    input logic               flush,
    mem_wb_pipe_reg_if.slave  bus
);

    typedef struct packed {
        logic [XLEN-1:0]    mem_read_data;
        logic [XLEN-1:0]    alu_out;
        logic [RADDR_W-1:0] rd;
        logic [2:0]         funct3;
        logic [CTRL_W-1:0]  ctrl;
    } entry_t;

    entry_t main_q;
    entry_t skid_q;
    entry_t in_entry;
    logic   main_valid;
    logic   skid_valid;
    logic   accept;
    logic   pop;
    logic   unused_bits;

    assign in_entry = '{
        mem_read_data: bus.mem_read_data,
        alu_out:       bus.alu_out,
        rd:            bus.rd,
        funct3:        bus.funct3,
        ctrl:          bus.ctrl
    };

    // Ready depends only on registered state, so out_ready never reaches in_ready.
    assign bus.in_ready = !skid_valid;
    assign accept       = bus.in_valid && !skid_valid && !flush;
    assign pop          = main_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid && pop) begin
            main_q     <= skid_q;
            skid_valid <= 1'b0;
        end else if (accept && (!main_valid || pop)) begin
            main_q     <= in_entry;
            main_valid <= 1'b1;
        end else if (accept) begin
            skid_q     <= in_entry;
            skid_valid <= 1'b1;
        end else if (pop) begin
            main_valid <= 1'b0;
        end
    end

`ifdef MEM_WB_LOAD_ALIGN_EN
    // Alignment works on the low word only; alu_out[0] is ignored for halves.
    function automatic logic [XLEN-1:0] load_data(input entry_t e);
        logic [31:0] word;
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        word   = e.mem_read_data[31:0];
        byte_v = word[8*e.alu_out[1:0] +: 8];
        half_v = e.alu_out[1] ? word[31:16] : word[15:0];
        case (e.funct3)
            3'b000:  return XLEN'($signed(byte_v));
            3'b100:  return XLEN'(byte_v);
            3'b001:  return XLEN'($signed(half_v));
            3'b101:  return XLEN'(half_v);
            default: return XLEN'($signed(word));
        endcase
    endfunction
`else
    function automatic logic [XLEN-1:0] load_data(input entry_t e);
        return e.mem_read_data;
    endfunction
`endif

    assign bus.out_valid = main_valid;
    assign bus.wb_data   = main_q.ctrl[WB_SEL_BIT] ? load_data(main_q) : main_q.alu_out;
    assign bus.wb_rd     = main_q.rd;
    assign bus.wb_we     = main_valid && main_q.ctrl[RWE_BIT] && (main_q.rd != '0);

    assign unused_bits = ^main_q;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Directed bench for mem_wb_pipe_reg: queue-based reference model checked every cycle
// plus hand-computed literal expectations from the test plan.
module tb_mem_wb_pipe_reg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int CTRL_W  = 8;

    logic clk;
    logic rst;
    logic flush;
    int   errors;
    int   checks;

    mem_wb_pipe_reg_if #(.XLEN(XLEN), .RADDR_W(RADDR_W), .CTRL_W(CTRL_W)) bus ();

    mem_wb_pipe_reg #(
        .XLEN(XLEN), .RADDR_W(RADDR_W), .CTRL_W(CTRL_W), .WB_SEL_BIT(2), .RWE_BIT(0)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0]    data;
        logic [RADDR_W-1:0] rd;
        bit                 we;
    } exp_t;

    exp_t model_q[$];
    bit   m_pop;
    bit   m_acc;
    exp_t m_new;

    function automatic logic [XLEN-1:0] exp_load(logic [XLEN-1:0] mem, logic [XLEN-1:0] alu,
                                                 logic [2:0] f3);
`ifdef MEM_WB_LOAD_ALIGN_EN
        longint w;
        longint b;
        longint h;
        longint v;
        w = longint'(mem[31:0]);
        b = (w >> (8 * int'(alu[1:0]))) % 256;
        h = (w >> (16 * int'(alu[1]))) % 65536;
        case (f3)
            3'd0:    v = (b >= 128) ? b - 256 : b;
            3'd4:    v = b;
            3'd1:    v = (h >= 32768) ? h - 65536 : h;
            3'd5:    v = h;
            default: v = (w >= 64'h8000_0000) ? w - 64'h1_0000_0000 : w;
        endcase
        return XLEN'(v);
`else
        if (alu == '1 && f3 == 3'b111) return mem;
        return mem;
`endif
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of at most two results, updated at each edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_q.delete();
        end else if (flush) begin
            model_q.delete();
        end else begin
            m_pop = (model_q.size() > 0) && bus.out_ready;
            m_acc = bus.in_valid && (model_q.size() < 2);
            if (m_pop) void'(model_q.pop_front());
            if (m_acc) begin
                m_new.data = bus.ctrl[2] ? exp_load(bus.mem_read_data, bus.alu_out, bus.funct3)
                                         : bus.alu_out;
                m_new.rd   = bus.rd;
                m_new.we   = bus.ctrl[0] && (bus.rd != 0);
                model_q.push_back(m_new);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("reset_outputs", {bus.out_valid, bus.wb_we, bus.in_ready, bus.wb_rd, bus.wb_data},
                  {1'b0, 1'b0, 1'b1, {RADDR_W{1'b0}}, {XLEN{1'b0}}});
        end else begin
            check("model_out_valid", 64'(bus.out_valid), 64'(model_q.size() > 0));
            check("model_in_ready", 64'(bus.in_ready), 64'(model_q.size() < 2));
            if (model_q.size() > 0) begin
                check("model_wb_data", 64'(bus.wb_data), 64'(model_q[0].data));
                check("model_wb_rd", 64'(bus.wb_rd), 64'(model_q[0].rd));
                check("model_wb_we", 64'(bus.wb_we), 64'(model_q[0].we));
            end else begin
                check("model_wb_we_idle", 64'(bus.wb_we), 64'd0);
            end
        end
    end

    task automatic applyStimulus(bit v, logic [XLEN-1:0] mem, logic [XLEN-1:0] alu,
                                 logic [RADDR_W-1:0] rd_i, logic [2:0] f3,
                                 logic [CTRL_W-1:0] ctrl_i, bit ordy, bit fl);
        bus.in_valid      = v;
        bus.mem_read_data = mem;
        bus.alu_out       = alu;
        bus.rd            = rd_i;
        bus.funct3        = f3;
        bus.ctrl          = ctrl_i;
        bus.out_ready     = ordy;
        flush             = fl;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(string name, bit ev, logic [XLEN-1:0] ed, logic [RADDR_W-1:0] er,
                               bit ew, bit erdy, bit check_data);
        @(negedge clk);
        check({name, "_valid"}, 64'(bus.out_valid), 64'(ev));
        check({name, "_we"}, 64'(bus.wb_we), 64'(ew));
        check({name, "_in_ready"}, 64'(bus.in_ready), 64'(erdy));
        if (check_data) begin
            check({name, "_data"}, 64'(bus.wb_data), 64'(ed));
            check({name, "_rd"}, 64'(bus.wb_rd), 64'(er));
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        applyStimulus(0, '0, '0, '0, 3'd0, '0, 1'b0, 1'b0);
        cycle();
        cycle();
        checkOutput("reset", 0, '0, '0, 0, 1, 1);

        cycle();
        rst = 1'b1;
        applyStimulus(1, '0, 32'h0000_1234, 5'd5, 3'd0, 8'h01, 1'b1, 1'b0);
        cycle();
        applyStimulus(0, '0, '0, '0, 3'd0, '0, 1'b1, 1'b0);
        checkOutput("single", 1, 32'h1234, 5'd5, 1, 1, 1);
        cycle();
        checkOutput("drain", 0, '0, '0, 0, 1, 0);

        $display("[TB] mid-run reset");
        applyStimulus(1, '0, 32'h55, 5'd7, 3'd0, 8'h01, 1'b0, 1'b0);
        cycle();
        applyStimulus(0, '0, '0, '0, 3'd0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        checkOutput("midreset", 0, '0, '0, 0, 1, 1);
        cycle();
        rst = 1'b1;

        $display("[TB] back-pressure");
        applyStimulus(1, '0, 32'hA, 5'd1, 3'd0, 8'h01, 1'b0, 1'b0);
        cycle();
        applyStimulus(1, '0, 32'hB, 5'd2, 3'd0, 8'h01, 1'b0, 1'b0);
        checkOutput("bp_A", 1, 32'hA, 5'd1, 1, 1, 1);
        cycle();
        applyStimulus(0, '0, '0, '0, 3'd0, '0, 1'b0, 1'b0);
        checkOutput("bp_B", 1, 32'hA, 5'd1, 1, 0, 1);
        cycle();
        checkOutput("bp_hold", 1, 32'hA, 5'd1, 1, 0, 1);
        applyStimulus(0, '0, '0, '0, 3'd0, '0, 1'b1, 1'b0);
        cycle();
        checkOutput("bp_pop1", 1, 32'hB, 5'd2, 1, 1, 1);
        cycle();
        checkOutput("bp_pop2", 0, '0, '0, 0, 1, 0);

        $display("[TB] flush with both entries full");
        applyStimulus(1, '0, 32'hC, 5'd3, 3'd0, 8'h01, 1'b0, 1'b0);
        cycle();
        applyStimulus(1, '0, 32'hD, 5'd4, 3'd0, 8'h01, 1'b0, 1'b0);
        cycle();
        applyStimulus(1, '0, 32'hE, 5'd6, 3'd0, 8'h01, 1'b0, 1'b1);
        checkOutput("full", 1, 32'hC, 5'd3, 1, 0, 1);
        cycle();
        applyStimulus(0, '0, '0, '0, 3'd0, '0, 1'b1, 1'b0);
        checkOutput("flush", 0, '0, '0, 0, 1, 0);
        cycle();
        checkOutput("flush_gone", 0, '0, '0, 0, 1, 0);

        applyStimulus(1, '0, 32'hFFFF, 5'd0, 3'd0, 8'h01, 1'b1, 1'b0);
        cycle();
        applyStimulus(1, 32'hDEAD_BEEF, 32'h100, 5'd9, 3'd2, 8'h05, 1'b1, 1'b0);
        checkOutput("x0", 1, 32'hFFFF, 5'd0, 0, 1, 1);
        cycle();
        applyStimulus(0, '0, '0, '0, 3'd0, '0, 1'b1, 1'b0);
        checkOutput("memsel", 1, 32'hDEAD_BEEF, 5'd9, 1, 1, 1);
        cycle();

        $display("[TB] load formats");
`ifdef MEM_WB_LOAD_ALIGN_EN
        applyStimulus(1, 32'h80FF_7F01, 32'h1001, 5'd10, 3'b000, 8'h05, 1'b1, 1'b0);
        cycle();
        checkOutput("lb", 1, 32'h0000_007F, 5'd10, 1, 1, 1);
        applyStimulus(1, 32'h80FF_7F01, 32'h1003, 5'd10, 3'b100, 8'h05, 1'b1, 1'b0);
        cycle();
        checkOutput("lbu", 1, 32'h0000_0080, 5'd10, 1, 1, 1);
        applyStimulus(1, 32'h80FF_7F01, 32'h1002, 5'd10, 3'b001, 8'h05, 1'b1, 1'b0);
        cycle();
        checkOutput("lh", 1, 32'hFFFF_80FF, 5'd10, 1, 1, 1);
        applyStimulus(1, 32'h80FF_7F01, 32'h1000, 5'd10, 3'b101, 8'h05, 1'b1, 1'b0);
        cycle();
        checkOutput("lhu", 1, 32'h0000_7F01, 5'd10, 1, 1, 1);
`else
        applyStimulus(1, 32'h80FF_7F01, 32'h1001, 5'd10, 3'b000, 8'h05, 1'b1, 1'b0);
        cycle();
        checkOutput("raw_lb", 1, 32'h80FF_7F01, 5'd10, 1, 1, 1);
        applyStimulus(1, 32'h80FF_7F01, 32'h1002, 5'd10, 3'b101, 8'h05, 1'b1, 1'b0);
        cycle();
        checkOutput("raw_lhu", 1, 32'h80FF_7F01, 5'd10, 1, 1, 1);
`endif
        applyStimulus(0, '0, '0, '0, 3'd0, '0, 1'b1, 1'b0);
        cycle();

        $display("[TB] streaming with intermittent back-pressure");
        for (int i = 0; i < 24; i++) begin
            applyStimulus((i % 3) != 0, 32'hA500_0000 | 32'(i * 4099), 32'(32'h100 + i * 4),
                          RADDR_W'(i), 3'(i), CTRL_W'(i * 37), (i % 4) != 1, 1'b0);
            cycle();
        end
        applyStimulus(0, '0, '0, '0, 3'd0, '0, 1'b1, 1'b0);
        cycle();
        cycle();
        checkOutput("final_idle", 0, '0, '0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_pipe_reg.md
Name: mem_wb_pipe_reg

Overview:
Parametrised successor to the MEM/WB pipeline register. Sits between the memory stage and the register-file write port, with a valid/ready handshake on both sides. A 2-entry skid buffer lets writeback back-pressure without dropping results. The block also flushes, selects the writeback data, and gates the register write enable.

Parameters:
XLEN, 32, datapath width (must be >= 32)
RADDR_W, 5, destination register index width
CTRL_W, 8, control bundle width from control unit
WB_SEL_BIT, 2, ctrl bit: 1 = write memory data, 0 = write ALU result
RWE_BIT, 0, ctrl bit: register write enable

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
flush  input  1  synchronous kill of all buffered entries
in_valid  input  1  memory stage presents a result
in_ready  output  1  block can accept this cycle
mem_read_data  input  XLEN  load data from data memory
alu_out  input  XLEN  ALU result / load address
rd  input  RADDR_W  destination register
funct3  input  3  load format (used only with optional feature)
ctrl  input  CTRL_W  control bundle
out_valid  output  1  wb_* outputs hold a valid entry
out_ready  input  1  write port consumes the entry this cycle
wb_data  output  XLEN  selected writeback data
wb_rd  output  RADDR_W  destination register of head entry
wb_we  output  1  out_valid & ctrl[RWE_BIT] & (wb_rd != 0)

Behaviour:
- Storage:
  - main entry: data + valid, drives wb_* outputs.
  - skid entry: data + valid.
  - Stored fields per entry: mem_read_data, alu_out, rd, funct3, ctrl.
- Reset (rst=0, asynchronous): both valids=0 and all fields 0. So out_valid=0, wb_data=0, wb_rd=0, wb_we=0, in_ready=1.
- Handshake signals:
  - in_ready = !skid_valid (registered-state only, no combinational path from out_ready).
  - accept = in_valid & in_ready & !flush.
  - pop = out_valid & out_ready.
- Per-cycle update, non-flush (priority order):
  - skid_valid & pop: skid moves to main; skid_valid=0. Accept is impossible here because in_ready=0.
  - accept & (!main_valid | pop): input goes to main.
  - accept & main_valid & !pop: input goes to skid; skid_valid=1.
  - pop with no refill: main_valid=0.
  - no pop: main holds.
- Latency: a result accepted in cycle N appears on wb_* in cycle N+1 when main is empty or popping.
- Ordering: strictly FIFO; skid never overtakes main.
- Flush=1 at an edge: main_valid=0 and skid_valid=0; any concurrent input is discarded. Field contents are don't-care, but wb_we must be 0 whenever out_valid=0. in_ready=1 the next cycle.
- wb_data is combinational from main:
  - ctrl[WB_SEL_BIT] ? load_data(main) : alu_out.
  - load_data = raw mem_read_data unless the optional feature is compiled in.
- wb_we is forced 0 for rd=0 (x0 never written).
- Outputs are stable while out_valid & !out_ready.

Optional Feature:
MEM_WB_LOAD_ALIGN_EN
- Defined: load_data is aligned from the low 32 bits of mem_read_data using alu_out[1:0], then extended to XLEN.
  - funct3=000 (LB): byte [8*a+7:8*a], sign-extended.
  - 100 (LBU): same byte, zero-extended.
  - 001 (LH): half at alu_out[1], sign-extended.
  - 101 (LHU): same half, zero-extended.
  - 010 (LW) and all other codes: word, sign-extended to XLEN.
  - alu_out[0] is ignored for halves.
- Undefined: load_data = mem_read_data unchanged; funct3 is stored but unused.

Test Plan:
- Reset, then a single transfer:
  - Stimulus: rst=0 mid-run, then release. in_valid=1, alu_out=0x0000_1234, rd=5, ctrl=0x01, out_ready=1.
  - Response: all outputs 0 while rst=0. Next cycle out_valid=1, wb_data=0x1234, wb_rd=5, wb_we=1.
- Back-pressure:
  - Stimulus: out_ready=0, push A (alu 0xA) then B (alu 0xB).
  - Response: after A, in_ready=1; after B, in_ready=0 and wb_data=0xA held.
  - Then out_ready=1: wb_data=0xA, then 0xB; in_ready=1 one cycle after A pops.
- Flush with both entries full and in_valid=1:
  - Response: next cycle out_valid=0, wb_we=0, in_ready=1; the flushed input never appears.
- x0 suppression: rd=0, ctrl=0x01, alu 0xFFFF → out_valid=1, wb_we=0.
- Memory select: ctrl=0x05, mem_read_data=0xDEADBEEF → wb_data=0xDEADBEEF (macro undefined).
- With MEM_WB_LOAD_ALIGN_EN, mem_read_data=0x80FF7F01:
  - LB at addr ...01 → 0x0000007F.
  - LBU at addr ...03 → 0x00000080.
  - LH at addr ...02 → 0xFFFF80FF.
  - LHU at addr ...00 → 0x00007F01.
